// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder cell, one bit per clock, LSB first.
// Ports: clk, rst_n, start, a, b, cin, sub -> busy, done, sum, cout, ovf.
// Optional subtract mode: define SERIAL_ADD_SUB_EN.

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic c,
  output logic s
);
  logic xy;
  assign xy = x ^ y;
  assign s  = xy ^ z;
  assign c  = (x & y) | (z & xy);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic             msb_cin;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             fa_c;
  logic             fa_s;

  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  fa_cell u_fa (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .z (carry),
    .c (fa_c),
    .s (fa_s)
  );

`ifdef SERIAL_ADD_SUB_EN
  // a - b == a + ~b + 1
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign last = (cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nx = fa_s;
    end else begin : g_wn
      assign sum_nx = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b_ld;
        carry <= c_ld;
        cnt   <= '0;
      end else if (busy) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_nx;
        carry  <= fa_c;
        cnt    <= cnt + 1'b1;
        // Final bit: publish result as DONE is entered.
        if (last) begin
          msb_cin <= carry;
          sum     <= sum_nx;
          cout    <= fa_c;
          ovf     <= carry ^ fa_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Table-driven vectors plus handshake, back-to-back and reset-abort sequences.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        nm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge after accept.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is);
    @(negedge clk);
    a     = ia;
    b     = ib;
    cin   = ic;
    sub   = is;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
  endtask

  // Wait (bounded) for done; check latency, busy cycles and result.
  task automatic finish_op(input string nm, input int exp_lat,
                           input logic [W-1:0] es, input logic eco,
                           input logic eov);
    int lat;
    int bc;
    lat = 0;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_busy"}, bc, exp_lat);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(eco));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eov));
  endtask

  task automatic do_op(input vec_t v);
    launch(v.a, v.b, v.cin, v.sub);
    finish_op(v.nm, W, v.s, v.co, v.ov);
    @(negedge clk);
    chk({v.nm, "_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({v.nm, "_hold"}, 32'(sum), 32'(v.s));
  endtask

  initial begin
    int seen;

    vt[0] = '{"add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vt[1] = '{"add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{"add_cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vt[3] = '{"add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[4] = '{"add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
`ifdef SERIAL_ADD_SUB_EN
    vt[5] = '{"sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[6] = '{"sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[7] = '{"sub_0_plain", 8'h05, 8'h07, 1'b1, 1'b0, 8'h0D, 1'b0, 1'b0};
`else
    vt[5] = '{"nosub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0};
    vt[6] = '{"nosub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vt[7] = '{"add_c0_40", 8'hC0, 8'h40, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
`endif
    vt[8] = '{"add_12_34", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    #1;
    chk("in_reset", {busy, done, cout, ovf, 20'd0, sum}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outs", {busy, done, cout, ovf, 20'd0, sum}, 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      do_op(vt[i]);
    end

    // Start during RUN is ignored; outputs hold prior result meanwhile.
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    chk("run_hold_sum", 32'(sum), 32'h47);
    @(negedge clk);
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignore", W - 3, 8'h30, 1'b0, 1'b0);

    // Start held through DONE: accepted with no IDLE cycle.
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {30'd0, busy, done}, 32'd2);
    finish_op("b2b", W, 8'h03, 1'b0, 1'b0);

    // Reset mid-RUN aborts immediately and clears the result.
    launch(8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    do_op('{"post_rst_7f", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
